// File: rtl/apb_ucpd_biu4.sv
// APB4 bus interface unit for the UCPD register block: latches each transfer, strobes the
// register file, waits for ip_ack and completes with pready/pslverr. Access timeout: UCPD_BIU_TIMEOUT_EN.
module apb_ucpd_biu4 #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 48,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                                  pclk,
    input  logic                                  presetn,
    input  logic                                  psel,
    input  logic                                  penable,
    input  logic                                  pwrite,
    input  logic [ADDR_W-1:0]                     paddr,
    input  logic [DATA_W-1:0]                     pwdata,
    input  logic [DATA_W/8-1:0]                   pstrb,
    output logic [DATA_W-1:0]                     prdata,
    output logic                                  pready,
    output logic                                  pslverr,
    output logic                                  wr_en,
    output logic                                  rd_en,
    output logic [DATA_W/8-1:0]                   byte_en,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0]    reg_addr,
    output logic [DATA_W-1:0]                     ipwdata,
    input  logic [DATA_W-1:0]                     iprdata,
    input  logic                                  ip_ack,
    input  logic                                  ip_err
);

    localparam int LANES = DATA_W / 8;
    localparam int LW    = $clog2(LANES);
    localparam int RW    = ADDR_W - LW;
    localparam logic [31:0] NUM_REGS_U = NUM_REGS;

    typedef enum logic [1:0] {IDLE, STRB, WAIT, DONE} state_t;

    state_t            state_reg, state_next;
    logic              write_reg, write_next;
    logic              range_err_reg, range_err_next;
    logic [DATA_W-1:0] prdata_reg, prdata_next;
    logic              pready_reg, pready_next;
    logic              pslverr_reg, pslverr_next;
    logic              wr_en_reg, wr_en_next;
    logic              rd_en_reg, rd_en_next;
    logic [LANES-1:0]  byte_en_reg, byte_en_next;
    logic [RW-1:0]     reg_addr_reg, reg_addr_next;
    logic [DATA_W-1:0] ipwdata_reg, ipwdata_next;

    logic [RW-1:0]     setup_addr;
    logic              setup_range;
    logic [LANES-1:0]  setup_lanes;
    logic              timeout;
    logic              fin;
    logic              fin_err;

    assign setup_addr  = paddr[ADDR_W-1:LW];
    assign setup_range = (32'(setup_addr) >= NUM_REGS_U);

    // Reads always enable every lane; writes take the bus strobes.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign setup_lanes[gi] = pwrite ? pstrb[gi] : 1'b1;
        end
    endgenerate

`ifdef UCPD_BIU_TIMEOUT_EN
    logic [7:0] cnt_reg;

    // Counts cycles spent in STRB/WAIT; equals k in the (k+1)-th access cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_reg <= '0;
        end else if (state_reg == STRB || state_reg == WAIT) begin
            cnt_reg <= cnt_reg + 8'd1;
        end else begin
            cnt_reg <= '0;
        end
    end

    assign timeout = (cnt_reg == 8'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg     <= IDLE;
            write_reg     <= 1'b0;
            range_err_reg <= 1'b0;
            prdata_reg    <= '0;
            pready_reg    <= 1'b0;
            pslverr_reg   <= 1'b0;
            wr_en_reg     <= 1'b0;
            rd_en_reg     <= 1'b0;
            byte_en_reg   <= '0;
            reg_addr_reg  <= '0;
            ipwdata_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            write_reg     <= write_next;
            range_err_reg <= range_err_next;
            prdata_reg    <= prdata_next;
            pready_reg    <= pready_next;
            pslverr_reg   <= pslverr_next;
            wr_en_reg     <= wr_en_next;
            rd_en_reg     <= rd_en_next;
            byte_en_reg   <= byte_en_next;
            reg_addr_reg  <= reg_addr_next;
            ipwdata_reg   <= ipwdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        write_next     = write_reg;
        range_err_next = range_err_reg;
        prdata_next    = prdata_reg;
        pready_next    = 1'b0;
        pslverr_next   = 1'b0;
        wr_en_next     = 1'b0;
        rd_en_next     = 1'b0;
        byte_en_next   = byte_en_reg;
        reg_addr_next  = reg_addr_reg;
        ipwdata_next   = ipwdata_reg;
        fin            = 1'b0;
        fin_err        = 1'b0;

        case (state_reg)
            IDLE: begin
                // Strobes are decided here so they are registered into the STRB cycle.
                if (psel && !penable) begin
                    state_next     = STRB;
                    write_next     = pwrite;
                    range_err_next = setup_range;
                    reg_addr_next  = setup_addr;
                    ipwdata_next   = pwdata;
                    byte_en_next   = setup_lanes;
                    wr_en_next     = pwrite && !setup_range && (pstrb != '0);
                    rd_en_next     = !pwrite && !setup_range;
                end
            end
            STRB: begin
                if (!psel) begin
                    state_next = IDLE;
                end else if (range_err_reg) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (write_reg && (byte_en_reg == '0)) begin
                    fin = 1'b1;
                end else if (ip_ack) begin
                    fin     = 1'b1;
                    fin_err = ip_err;
                end else if (timeout) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_next = IDLE;
                end else if (ip_ack) begin
                    fin     = 1'b1;
                    fin_err = ip_err;
                end else if (timeout) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (fin) begin
            state_next   = DONE;
            pready_next  = 1'b1;
            pslverr_next = fin_err;
            if (!write_reg) begin
                prdata_next = fin_err ? '0 : iprdata;
            end
        end
    end

    assign prdata   = prdata_reg;
    assign pready   = pready_reg;
    assign pslverr  = pslverr_reg;
    assign wr_en    = wr_en_reg;
    assign rd_en    = rd_en_reg;
    assign byte_en  = byte_en_reg;
    assign reg_addr = reg_addr_reg;
    assign ipwdata  = ipwdata_reg;

endmodule

// File: doc/apb_ucpd_biu4.md
# apb_ucpd_biu4

Parametrised APB4 bus interface unit for the UCPD peripheral register block. Sits between the system APB bus and the UCPD register file: decodes and latches each transfer, issues single-cycle write/read strobes with byte lanes, waits on a register-side acknowledge, and completes the transfer with `pready`/`pslverr`. It adds generic data/address width, write strobes, wait states, address-range and slave-error reporting, and an optional access timeout.

## Interface
- `ADDR_W`, 8: APB address width.
- `DATA_W`, 32: data width. Must be 32 or 64. `LANES = DATA_W/8`. `LW = log2(LANES)`.
- `NUM_REGS`, 48: number of implemented word registers. Valid offsets are `0..NUM_REGS-1`.
- `TIMEOUT_CYC`, 16: cycles to wait for `ip_ack` before an error completion. Range 2..255.
- `pclk`, in, 1: APB clock. This is the only clock.
- `presetn`, in, 1: asynchronous, active-low reset.
- `psel`, `penable`, `pwrite`, in, 1 each: APB control.
- `paddr`, in, ADDR_W: byte address.
- `pwdata`, in, DATA_W: write data.
- `pstrb`, in, LANES: write byte strobes.
- `prdata`, out, DATA_W: read data.
- `pready`, out, 1: transfer complete.
- `pslverr`, out, 1: transfer error.
- `wr_en`, `rd_en`, out, 1 each: one-cycle register strobes.
- `byte_en`, out, LANES: active byte lanes.
- `reg_addr`, out, ADDR_W-LW: word offset, equal to `paddr[ADDR_W-1:LW]`.
- `ipwdata`, out, DATA_W: latched write data.
- `iprdata`, in, DATA_W: register read data. Valid when `ip_ack` is high.
- `ip_ack`, in, 1: register side finished the access.
- `ip_err`, in, 1: qualifies `ip_ack` as an error.

## Operation
- FSM states: IDLE, STRB, WAIT, DONE.
- **IDLE:** on setup (`psel & !penable`), latch the following and go to STRB:
  - `reg_addr`
  - `pwrite`
  - `ipwdata`
  - `byte_en`: `pstrb` for a write, all ones for a read.
  - range flag: `reg_addr >= NUM_REGS`.
- **STRB, access phase:**
  - Out of range: no strobe, go to DONE with error.
  - Write with `pstrb == 0`: no strobe, go to DONE with no error.
  - Otherwise pulse `wr_en` or `rd_en` for exactly this cycle. If `ip_ack` is high this cycle, go to DONE. Otherwise go to WAIT.
- **WAIT:** hold `byte_en`, `reg_addr` and `ipwdata`. Count cycles. Go to DONE when `ip_ack` is high.
- **DONE:**
  - `pready = 1` for one cycle.
  - `pslverr = 1` in three cases: range error, `ip_err` sampled with `ip_ack`, or timeout.
  - Then go to IDLE.
- `prdata` updates only on a successful read completion, from `iprdata` sampled with `ip_ack`. An errored read drives `prdata = 0`. Otherwise `prdata` holds its last value.
- Abort: `psel` low in STRB or WAIT returns the FSM to IDLE next cycle with no `pready`. A late `ip_ack` in IDLE is ignored.
- `penable` high without a preceding setup in IDLE is ignored.
- `ip_ack` and `ip_err` are sampled only in STRB and WAIT.

## Timing
- All outputs are registered.
- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, `wr_en`=0, `rd_en`=0, `byte_en`=0, `reg_addr`=0, `ipwdata`=0, FSM in IDLE.
- Reset mid-transfer: all outputs return to reset values immediately. No completion is signalled.
- Cycle sequence, with T0 = setup:
  - T1: access phase, state STRB, strobe visible.
  - `ip_ack` at T1: `pready` at T2. Minimum transfer is 3 cycles, i.e. 1 wait state.
  - `ip_ack` at T1+n: `pready` at T2+n.
- `pready` and `pslverr` are never high outside DONE.
- Back-to-back: a setup phase in the cycle after DONE is accepted.

## Configuration
- `UCPD_BIU_TIMEOUT_EN` defined: an 8-bit counter runs in STRB and WAIT. If it reaches `TIMEOUT_CYC` without `ip_ack`, the FSM goes to DONE with `pslverr = 1`. An errored read returns `prdata = 0`.
- `UCPD_BIU_TIMEOUT_EN` undefined: no counter. WAIT lasts until `ip_ack` or abort. `pslverr` comes only from range errors and `ip_err`.

## Test plan
- Write `paddr`=0x10, `pwdata`=0xA5A5_1234, `pstrb`=0b0110, `ip_ack` at T1 -> `wr_en` only at T1, `reg_addr`=4, `byte_en`=0b0110, `pready`=1 and `pslverr`=0 at T2.
- Read `paddr`=0x08, `ip_ack` at T4 with `iprdata`=0xDEAD_BEEF -> `rd_en` only at T1, `pready` at T5, `prdata`=0xDEAD_BEEF held through later writes.
- Read at offset 0xC0 (=48 words) with default `NUM_REGS` -> no `rd_en`, `pready`=1 and `pslverr`=1 at T2, `prdata`=0.
- `UCPD_BIU_TIMEOUT_EN` defined, `TIMEOUT_CYC`=16, `ip_ack` held low -> `pready`=1 and `pslverr`=1 exactly 16 cycles after STRB entry. Repeat with the macro undefined: no `pready` after 100 cycles, then `ip_ack` -> `pready` next cycle.
- Write with `ip_ack` and `ip_err` at T2 -> `pslverr`=1 at T3. A back-to-back read setup at T4 completes normally.
- Drop `presetn` during WAIT, release after 2 cycles -> all outputs 0, no `pready`. The next read completes normally.
